// File: rtl/i2c_defs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_defs (package)
//  Description : Shared I2C definitions: FSM state encodings and the bit
//                counter width, common to the bus monitor and the master.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_defs;

  // Bit counter must hold 0..8 (eight data bits plus the ACK slot)
  localparam int c_BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } i2c_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_filter
//  Description : Synchronizer chain plus glitch filter for one I2C line.
//                The filtered output only follows the synchronized line after
//                FILTER_LEN consecutive samples of the new level. Every flop
//                resets to 1 so reset release looks like an idle bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  // A one-sample filter still needs a 1-bit counter to keep the code uniform
  localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [c_CNT_W-1:0]     cnt_q;
  logic                   filt_q;
  logic                   w_sync;

  assign w_sync = sync_q[SYNC_STAGES-1];
  assign line_o = filt_q;

  // Synchronize the raw line, then require a stable run before following it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      if (w_sync != filt_q) begin
        if (cnt_q == c_CNT_W'(FILTER_LEN - 1)) begin
          filt_q <= w_sync;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any return to the current level restarts the stability run
        cnt_q <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_monitor
//  Description : Passive I2C observer. Filters SCL/SDA, detects START/STOP,
//                deserializes each byte with its ACK bit and emits one-cycle
//                strobes. Never drives the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor
  import i2c_defs::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ack,
  output logic       byte_first,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       err
);

  logic w_scl_f, w_sda_f;
  logic scl_prev_q, sda_prev_q;
  logic w_scl_rise, w_scl_stable_hi, w_start, w_stop, w_partial;

  i2c_state_t             state_q;
  logic [c_BIT_CNT_W-1:0] bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   first_q;

  logic [7:0] byte_data_q;
  logic       byte_valid_q, byte_ack_q, byte_first_q;
  logic       start_det_q, stop_det_q, bus_busy_q, err_q;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (scl),
    .line_o (w_scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (sda),
    .line_o (w_sda_f)
  );

  // One-cycle-delayed copies of the filtered lines for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= w_scl_f;
      sda_prev_q <= w_sda_f;
    end
  end

  // SCL high before and after means any simultaneous SCL change suppresses START/STOP
  assign w_scl_stable_hi = w_scl_f & scl_prev_q;
  assign w_scl_rise      = w_scl_f & ~scl_prev_q;
  assign w_start         = w_scl_stable_hi & sda_prev_q & ~w_sda_f;
  assign w_stop          = w_scl_stable_hi & ~sda_prev_q & w_sda_f;
  assign w_partial       = (bit_cnt_q != '0) || (state_q == ST_ACK);

  // Protocol FSM with registered strobes and byte capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      first_q      <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_ack_q   <= 1'b0;
      byte_first_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      bus_busy_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            start_det_q <= 1'b1;
            bus_busy_q  <= 1'b1;
            state_q     <= ST_DATA;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
          end else if (w_stop) begin
            stop_det_q <= 1'b1;
          end
        end
        default: begin
          if (w_start) begin
            // Repeated START: any partially received byte is dropped
            err_q       <= w_partial;
            start_det_q <= 1'b1;
            state_q     <= ST_DATA;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
          end else if (w_stop) begin
            err_q      <= w_partial;
            stop_det_q <= 1'b1;
            bus_busy_q <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
          end else if (w_scl_rise) begin
            if (state_q == ST_DATA) begin
              shift_q   <= {shift_q[6:0], w_sda_f};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == c_BIT_CNT_W'(7)) begin
                state_q <= ST_ACK;
              end
            end else begin
              byte_data_q  <= shift_q;
              byte_ack_q   <= w_sda_f;
              byte_first_q <= first_q;
              byte_valid_q <= 1'b1;
              first_q      <= 1'b0;
              bit_cnt_q    <= '0;
              state_q      <= ST_DATA;
            end
          end
        end
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_ack   = byte_ack_q;
  assign byte_first = byte_first_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign bus_busy   = bus_busy_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_bus_monitor
//  Description : Directed self-checking bench for i2c_bus_monitor at default
//                parameters (2 sync stages, 3-sample filter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_monitor;

  localparam int c_Q = 4;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset, scl, sda;
  logic [7:0] byte_data;
  logic       byte_valid, byte_ack, byte_first;
  logic       start_det, stop_det, bus_busy, err;

  int n_cmp = 0;
  int n_fail = 0;

  int n_start = 0, n_stop = 0, n_err = 0, n_err_start = 0;
  int n_wide = 0, n_collide = 0;
  logic [9:0] bytes_q[$];
  logic prev_start = 1'b0, prev_stop = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;

  int b_start, b_stop, b_err, b_err_start, b_bytes, lat;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .byte_first (byte_first),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .err        (err)
  );

  // Observe strobes on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det) n_stop <= n_stop + 1;
    if (err) n_err <= n_err + 1;
    if (start_det && err) n_err_start <= n_err_start + 1;
    if (byte_valid && stop_det) n_collide <= n_collide + 1;
    if ((start_det && prev_start) || (stop_det && prev_stop) ||
        (byte_valid && prev_valid) || (err && prev_err)) n_wide <= n_wide + 1;
    if (byte_valid) bytes_q.push_back({byte_first, byte_ack, byte_data});
    prev_start <= start_det;
    prev_stop  <= stop_det;
    prev_valid <= byte_valid;
    prev_err   <= err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] byte_at(input int idx);
    if (idx < bytes_q.size()) return bytes_q[idx];
    return 10'h3FF;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda = 1'b0; cyc(c_Q);
    scl = 1'b0; cyc(c_Q);
  endtask

  task automatic i2c_rep_start();
    sda = 1'b1; cyc(c_Q);
    scl = 1'b1; cyc(c_Q);
    sda = 1'b0; cyc(c_Q);
    scl = 1'b0; cyc(c_Q);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; cyc(c_Q);
    scl = 1'b1; cyc(c_Q);
    sda = 1'b1; cyc(2 * c_Q);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    cyc(c_Q);
    scl = 1'b1; cyc(2 * c_Q);
    scl = 1'b0; cyc(c_Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ack);
  endtask

  task automatic snap();
    b_start     = n_start;
    b_stop      = n_stop;
    b_err       = n_err;
    b_err_start = n_err_start;
    b_bytes     = bytes_q.size();
  endtask

  initial begin
    reset = 1'b1; scl = 1'b1; sda = 1'b1;
    cyc(3);
    check("rst_byte_data", 32'(byte_data), 32'h00);
    check("rst_valid_ack_first", 32'({byte_valid, byte_ack, byte_first}), 32'h0);
    check("rst_start_stop_err", 32'({start_det, stop_det, err}), 32'h0);
    check("rst_bus_busy", 32'(bus_busy), 32'h0);
    reset = 1'b0;
    cyc(10);

    // Write transaction; its START doubles as the latency measurement
    snap();
    sda = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      cyc(1);
      if (start_det) lat = i;
    end
    check("start_latency", 32'(lat), 32'd6);
    check("busy_after_start", 32'(bus_busy), 32'h1);
    cyc(c_Q);
    scl = 1'b0; cyc(c_Q);
    send_byte(8'hA0, 1'b0);
    check("busy_mid_write", 32'(bus_busy), 32'h1);
    send_byte(8'h3C, 1'b1);
    i2c_stop();
    cyc(12);
    check("wr_start_count", 32'(n_start - b_start), 32'd1);
    check("wr_stop_count", 32'(n_stop - b_stop), 32'd1);
    check("wr_byte_count", 32'(bytes_q.size() - b_bytes), 32'd2);
    check("wr_byte0", 32'(byte_at(b_bytes)), 32'h2A0);
    check("wr_byte1", 32'(byte_at(b_bytes + 1)), 32'h13C);
    check("wr_byte_data_hold", 32'(byte_data), 32'h3C);
    check("wr_busy_after_stop", 32'(bus_busy), 32'h0);

    // Two-sample SDA glitch with SCL high must be filtered out
    snap();
    sda = 1'b0; cyc(2);
    sda = 1'b1; cyc(20);
    check("glitch_no_start", 32'(n_start - b_start), 32'd0);
    check("glitch_no_busy", 32'(bus_busy), 32'h0);

    // START, 4 bits, repeated START, then a full address byte
    snap();
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_rep_start();
    send_byte(8'h55, 1'b0);
    i2c_stop();
    cyc(12);
    check("rs_start_count", 32'(n_start - b_start), 32'd2);
    check("rs_err_with_start", 32'(n_err_start - b_err_start), 32'd1);
    check("rs_byte_count", 32'(bytes_q.size() - b_bytes), 32'd1);
    check("rs_byte0", 32'(byte_at(b_bytes)), 32'h255);

    // 20 SCL pulses without START
    snap();
    scl = 1'b0; cyc(c_Q);
    for (int i = 0; i < 20; i++) send_bit(logic'(i % 3 == 0));
    sda = 1'b1; cyc(c_Q);
    scl = 1'b1; cyc(12);
    check("idle_no_bytes", 32'(bytes_q.size() - b_bytes), 32'd0);
    check("idle_no_err", 32'(n_err - b_err), 32'd0);
    check("idle_no_start", 32'(n_start - b_start), 32'd0);
    check("idle_no_busy", 32'(bus_busy), 32'h0);

    // Reset asserted after 5 bits of a byte
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("busy_before_reset", 32'(bus_busy), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus_busy), 32'h0);
    check("midrst_byte_data", 32'(byte_data), 32'h00);
    check("midrst_strobes", 32'({byte_valid, byte_ack, byte_first, start_det, stop_det, err}), 32'h0);
    sda = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(10);
    snap();
    for (int i = 0; i < 9; i++) send_bit(logic'(i[0]));
    check("postrst_no_bytes", 32'(bytes_q.size() - b_bytes), 32'd0);
    check("postrst_no_err", 32'(n_err - b_err), 32'd0);
    check("postrst_no_busy", 32'(bus_busy), 32'h0);
    sda = 1'b1; cyc(c_Q);
    scl = 1'b1; cyc(c_Q);
    i2c_start();
    send_byte(8'hC3, 1'b0);
    i2c_stop();
    cyc(12);
    check("postrst_start_count", 32'(n_start - b_start), 32'd1);
    check("postrst_byte0", 32'(byte_at(b_bytes)), 32'h2C3);

    check("strobe_width_violations", 32'(n_wide), 32'd0);
    check("valid_stop_coincide", 32'(n_collide), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive I2C bus observer that sits directly downstream of the I2C master and slave on the shared `scl`/`sda` wires. It samples both lines in the system clock domain, filters them, detects START/STOP conditions, and deserializes every transferred byte together with its ACK bit. It outputs one-cycle strobes for logging, debug display or assertion checking. It never drives the bus.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per line, minimum 2.
- `FILTER_LEN`, default 3: consecutive identical synchronized samples required before a filtered line changes, minimum 1.
- `clk` input 1: system clock; must be ≥ 8× the SCL frequency.
- `reset` input 1: asynchronous, active-high reset.
- `scl` input 1: raw bus clock line, observed only.
- `sda` input 1: raw bus data line, observed only.
- `byte_data` output 8: last completed byte, MSB first on the bus; holds until the next byte completes.
- `byte_valid` output 1: one-cycle strobe; `byte_data`, `byte_ack` and `byte_first` are valid in this cycle.
- `byte_ack` output 1: 9th-bit SDA level; 0 = ACK, 1 = NACK.
- `byte_first` output 1: this byte is the first byte after a START or repeated START (the address byte).
- `start_det` output 1: one-cycle strobe on START or repeated START.
- `stop_det` output 1: one-cycle strobe on STOP.
- `bus_busy` output 1: high from START until STOP.
- `err` output 1: one-cycle strobe on a START or STOP received mid-byte.

## Operation
- Each line passes through `SYNC_STAGES` flops, then a glitch filter.
- The filtered value changes only after `FILTER_LEN` consecutive samples of the new level.
- All synchronizer and filter flops reset to 1 (idle bus), so reset release never creates a false edge.
- Edge detection compares the filtered value against its one-cycle-delayed copy.
- START: filtered SDA falls while filtered SCL is 1 before and after.
- STOP: filtered SDA rises while filtered SCL is 1 before and after.
- If SCL and SDA change in the same filtered cycle, no START/STOP is reported; only the SCL edge is processed.
- States: IDLE, DATA, ACK.
  - IDLE: SCL edges are ignored. START → DATA with `bit_cnt`=0 and `first_flag`=1.
  - DATA: on each SCL rising edge, shift SDA into the shift register and increment `bit_cnt`. On the 8th rising edge → ACK.
  - ACK: on the next SCL rising edge, capture SDA as the ack bit and pulse `byte_valid` with `byte_first`=`first_flag`. Then clear `first_flag` → DATA with `bit_cnt`=0.
- START in DATA/ACK: if `bit_cnt`≠0 or state=ACK, pulse `err` and discard the partial byte. Always pulse `start_det` and restart DATA with `first_flag`=1.
- STOP in any non-IDLE state → IDLE and pulse `stop_det`. Also pulse `err` if `bit_cnt`≠0 or state=ACK.
- STOP in IDLE: pulse `stop_det` only.
- `bus_busy` goes to 1 in the cycle `start_det` pulses and to 0 in the cycle `stop_det` pulses.

## Timing
- Reset values: `byte_data`=0x00; `byte_valid`, `byte_ack`, `byte_first`, `start_det`, `stop_det`, `bus_busy`, `err` all 0. FSM resets to IDLE, `bit_cnt` to 0.
- Reset asserted mid-transfer clears everything immediately. After release, the monitor stays in IDLE until a fresh START.
- Latency from a raw line edge to the corresponding strobe is exactly `SYNC_STAGES` + `FILTER_LEN` + 1 `clk` cycles (6 at defaults).
- All strobes are exactly one cycle wide.
- `byte_valid` and `stop_det` never coincide, because they come from distinct edges.
- `start_det` and `err` may coincide.

## Structure
- Shared package/header `i2c_defs`: FSM state encodings (IDLE, DATA, ACK) and the bit-count width constant, reused by the master.
- One sub-module, `i2c_line_filter` (synchronizer, glitch filter, registered output, reset to 1), instantiated once for `scl` and once for `sda`.

## Test plan
- Write transaction, at defaults: START, byte 0xA0 ACKed, byte 0x3C NACKed, STOP. Required response:
  - `start_det` pulses once.
  - `byte_valid` pulses twice: first 0xA0 with `byte_ack`=0 and `byte_first`=1, then 0x3C with `byte_ack`=1 and `byte_first`=0.
  - `stop_det` pulses once; `bus_busy` is high between START and STOP.
- 2-cycle low glitch on `sda` while `scl` is high (`FILTER_LEN`=3) → no `start_det`, `bus_busy` stays 0.
- START, 4 data bits, repeated START, byte 0x55 → `err` and `start_det` pulse in the same cycle; the next `byte_valid` carries 0x55 with `byte_first`=1.
- 20 SCL pulses with no START → no `byte_valid` and no `err`.
- `reset` asserted after 5 bits of a byte → all outputs 0 immediately. After release, 9 SCL pulses produce no `byte_valid` until a new START.
- Latency check: a raw `sda` fall with `scl`=1 → `start_det` exactly 6 `clk` cycles later at defaults.
